// File: rtl/udp_tx_pkt_gen_if.sv
// Bundle of the user word stream and the udp-core transmit handshake used by
// udp_tx_pkt_gen. The slave modport is the packet generator's view, the master
// modport is the view of whatever drives user words and plays the udp core.
interface udp_tx_pkt_gen_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        tx_pkg_done;
    logic        busy;
    logic [15:0] pkt_cnt;

    modport master (
        output in_valid, in_data, tx_req, tx_pkg_done,
        input  in_ready, tx_start_en, tx_byte_num, tx_data, busy, pkt_cnt
    );

    modport slave (
        input  in_valid, in_data, tx_req, tx_pkg_done,
        output in_ready, tx_start_en, tx_byte_num, tx_data, busy, pkt_cnt
    );
endinterface

// File: rtl/udp_tx_pkt_gen.sv
// udp_tx_pkt_gen: transmit-side payload source for the udp core.
// Buffers 32-bit user words in a circular RAM and frames them into packets of
// PKT_WORDS words: pulses tx_start_en with tx_byte_num, answers each tx_req with
// the next word one cycle later, then waits for tx_pkg_done.
// Optional feature macro TX_TIMEOUT_FLUSH_EN: when defined, a partial packet is
// flushed after TIMEOUT_CYC idle cycles; when undefined only full packets go out.
module udp_tx_pkt_gen #(
    parameter int DEPTH_LOG2  = 6,
    parameter int PKT_WORDS   = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    udp_tx_pkt_gen_if.slave bus
);
    localparam int              DEPTH      = 1 << DEPTH_LOG2;
    localparam int              PW         = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]   FULL_LEVEL = PW'(DEPTH);
    localparam logic [PW-1:0]   PKT_LEVEL  = PW'(PKT_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_WAIT_DONE
    } state_t;

    state_t        state_reg, state_next;

    logic [31:0]   buf_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0] level;
    logic [PW-1:0] n_reg, n_next;
    logic [PW-1:0] sent_reg, sent_next;
    logic [15:0]   byte_num_reg, byte_num_next;
    logic [15:0]   pkt_cnt_reg, pkt_cnt_next;
    logic [31:0]   tx_data_reg;
    logic          push, pop, zero_data, flush_go;

    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign push     = bus.in_valid && (level != FULL_LEVEL);

    assign bus.in_ready    = (level != FULL_LEVEL);
    assign bus.tx_start_en = (state_reg == S_START);
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.tx_byte_num = byte_num_reg;
    assign bus.tx_data     = tx_data_reg;
    assign bus.pkt_cnt     = pkt_cnt_reg;

`ifdef TX_TIMEOUT_FLUSH_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] timer_reg;

    // Idle timer: runs only while a partial packet sits untouched in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg <= '0;
        end else if (state_reg != S_IDLE || state_next != S_IDLE || push || level == '0) begin
            timer_reg <= '0;
        end else if (level < PKT_LEVEL) begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    assign flush_go = (level != '0) && (timer_reg == TW'(TIMEOUT_CYC - 1));
`else
    // No timer in this build: partial data waits for a full packet.
    assign flush_go = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    // Next-state and packet bookkeeping; packet size and byte count are frozen
    // on the IDLE->START edge so tx_byte_num is already valid with tx_start_en.
    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        sent_next     = sent_reg;
        byte_num_next = byte_num_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        pop           = 1'b0;
        zero_data     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (level >= PKT_LEVEL) begin
                    n_next        = PKT_LEVEL;
                    byte_num_next = 16'({PKT_LEVEL, 2'b00});
                    sent_next     = '0;
                    state_next    = S_START;
                end else if (flush_go) begin
                    n_next        = level;
                    byte_num_next = 16'({level, 2'b00});
                    sent_next     = '0;
                    state_next    = S_START;
                end
            end
            S_START: begin
                state_next = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_req) begin
                    if (sent_reg < n_reg) begin
                        pop       = 1'b1;
                        sent_next = sent_reg + PW'(1);
                        if (sent_reg + PW'(1) == n_reg) begin
                            state_next = S_WAIT_DONE;
                        end
                    end else begin
                        zero_data = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_req) begin
                    zero_data = 1'b1;
                end
                if (bus.tx_pkg_done) begin
                    pkt_cnt_next = pkt_cnt_reg + 16'd1;
                    state_next   = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control registers: FSM state, packet size, sent count, byte count, packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            n_reg        <= '0;
            sent_reg     <= '0;
            byte_num_reg <= '0;
            pkt_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            n_reg        <= n_next;
            sent_reg     <= sent_next;
            byte_num_reg <= byte_num_next;
            pkt_cnt_reg  <= pkt_cnt_next;
        end
    end

    // Buffer pointers and the registered read port that feeds tx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            tx_data_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PW'(1);
                tx_data_reg <= buf_mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
            end else if (zero_data) begin
                tx_data_reg <= '0;
            end
        end
    end

    // Payload RAM write port; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_udp_tx_pkt_gen.sv
// Self-checking bench for udp_tx_pkt_gen: random word stream and udp-core
// handshake, scored against a queue model of the payload buffer.
module tb_udp_tx_pkt_gen;
    localparam int DEPTH_LOG2  = 6;
    localparam int PKT_WORDS   = 16;
    localparam int TIMEOUT_CYC = 1000;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    udp_tx_pkt_gen_if bus ();

    udp_tx_pkt_gen #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .PKT_WORDS   (PKT_WORDS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_q[$];          // words accepted and not yet sent
    int          exp_n  = PKT_WORDS; // words the next packet must carry
    int          push_cyc = 0;

    // monitor model state
    bit          in_pkt = 0;
    int          left = 0;
    bit          pend = 0;
    logic [31:0] pend_exp = '0;
    logic [31:0] exp_last = '0;
    logic [15:0] exp_cnt = '0;
    logic [15:0] exp_bytes = '0;
    int          start_cyc = 0;
    int          start_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scores every cycle against the queue model.
    initial begin : monitor
        int          left_now;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_pkt = 0; left = 0; pend = 0; exp_last = '0; exp_cnt = '0; exp_bytes = '0;
                continue;
            end
            if (pend) begin
                exp_last = pend_exp;
                pend     = 0;
            end
            check("tx_data", bus.tx_data, exp_last);
            check("pkt_cnt", 32'(bus.pkt_cnt), 32'(exp_cnt));
            check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
            check("busy", 32'(bus.busy), 32'(in_pkt || bus.tx_start_en));
            left_now = left;
            if (bus.tx_req) begin
                pend = 1;
                if (!in_pkt) begin
                    pend_exp = exp_last;
                end else if (left > 0) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL model_underflow: got request for word with empty model, required data present");
                        pend_exp = '0;
                    end else begin
                        w = exp_q.pop_front();
                        pend_exp = w;
                    end
                    left--;
                end else begin
                    pend_exp = '0;
                end
            end
            if (bus.tx_pkg_done && in_pkt && left_now == 0) begin
                exp_cnt = exp_cnt + 16'd1;
                in_pkt  = 0;
            end
            if (bus.tx_start_en) begin
                check("start_while_busy", 32'(in_pkt), 32'(0));
                check("start_level_ok", 32'(exp_q.size() >= exp_n), 32'(1));
                exp_bytes   = 16'(4 * exp_n);
                left        = exp_n;
                in_pkt      = 1;
                start_cyc   = cyc;
                start_total++;
                $display("pkt start #%0d: tx_byte_num=%0d cycle %0d", start_total, bus.tx_byte_num, cyc);
            end
            check("tx_byte_num", 32'(bus.tx_byte_num), 32'(exp_bytes));
        end
    end

    // Present one word until accepted; the model records it after the accepting edge.
    task automatic push_word(input logic [31:0] w);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) push_cyc = cyc;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (ok) begin
            exp_q.push_back(w);
        end else begin
            checks++; errors++;
            $display("FAIL push_timeout: got in_ready=0 for 4000 cycles, required acceptance");
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_start(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            seen = bus.tx_start_en;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_timeout: got no tx_start_en within %0d cycles, required one", limit);
        end
        @(posedge clk); #1;
    endtask

    // Issue n word requests with random gaps and occasional stray tx_pkg_done.
    task automatic serve_reqs(input int n);
        int issued = 0;
        while (issued < n) begin
            bus.tx_req      = ($urandom_range(0, 3) != 0);
            bus.tx_pkg_done = !bus.tx_req && ($urandom_range(0, 15) == 0);
            if (bus.tx_req) issued++;
            @(posedge clk); #1;
        end
        bus.tx_req      = 1'b0;
        bus.tx_pkg_done = 1'b0;
    endtask

    // A few surplus requests, then the packet-done pulse.
    task automatic finish_pkt();
        int extra = $urandom_range(0, 3);
        repeat (extra) begin
            bus.tx_req = 1'b1;
            @(posedge clk); #1;
        end
        bus.tx_req      = 1'b0;
        bus.tx_pkg_done = 1'b1;
        @(posedge clk); #1;
        bus.tx_pkg_done = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_tx_start_en", 32'(bus.tx_start_en), 32'(0));
        check("rst_tx_byte_num", 32'(bus.tx_byte_num), 32'(0));
        check("rst_tx_data", bus.tx_data, 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'(0));
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got no completion by time limit, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int starts_before;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.tx_req      = 1'b0;
        bus.tx_pkg_done = 1'b0;

        // reset state
        idle_cycles(4);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // one full packet of 1..16, latency and count
        for (int i = 1; i <= 16; i++) push_word(32'(i));
        wait_start(20);
        check("start_latency", 32'(start_cyc - push_cyc), 32'(2));
        serve_reqs(16);
        finish_pkt();
        @(negedge clk);
        check("pkt_cnt_after_first", 32'(bus.pkt_cnt), 32'(1));
        check("busy_after_first", 32'(bus.busy), 32'(0));
        @(posedge clk); #1;

        // fill the buffer with no requests, then free one slot
        for (int i = 0; i < DEPTH; i++) push_word(32'h1000_0000 + 32'(i));
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check("full_reject", 32'(bus.in_ready), 32'(0));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.tx_req   = 1'b1;
        @(posedge clk); #1;
        bus.tx_req   = 1'b0;
        @(negedge clk);
        check("ready_after_pop", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1;
        serve_reqs(PKT_WORDS - 1);
        finish_pkt();
        for (int p = 0; p < 3; p++) begin
            wait_start(20);
            serve_reqs(PKT_WORDS);
            finish_pkt();
        end

        // random stream against random request pacing
        fork
            begin
                for (int k = 0; k < 48; k++) begin
                    idle_cycles($urandom_range(0, 3));
                    push_word($urandom);
                end
            end
            begin
                for (int p = 0; p < 3; p++) begin
                    wait_start(3000);
                    serve_reqs(PKT_WORDS);
                    finish_pkt();
                end
            end
        join

        // partial packet handling
`ifdef TX_TIMEOUT_FLUSH_EN
        exp_n = 5;
        for (int i = 0; i < 5; i++) push_word($urandom);
        wait_start(TIMEOUT_CYC + 50);
        check("flush_delay_in_range",
              32'((start_cyc - push_cyc) >= TIMEOUT_CYC && (start_cyc - push_cyc) <= TIMEOUT_CYC + 2),
              32'(1));
        exp_n = PKT_WORDS;
        serve_reqs(5);
        finish_pkt();
`else
        starts_before = start_total;
        for (int i = 0; i < 5; i++) push_word($urandom);
        idle_cycles(10000);
        check("no_partial_packet", 32'(start_total - starts_before), 32'(0));
        check("partial_not_busy", 32'(bus.busy), 32'(0));
        for (int i = 0; i < PKT_WORDS - 5; i++) push_word($urandom);
        wait_start(20);
        serve_reqs(PKT_WORDS);
        finish_pkt();
`endif

        // reset in the middle of a packet
        for (int i = 0; i < PKT_WORDS; i++) push_word(32'hA0A0_0000 + 32'(i));
        wait_start(20);
        serve_reqs(8);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        idle_cycles(3);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);
        for (int i = 0; i < PKT_WORDS; i++) push_word(32'h5500_0000 + 32'(i));
        wait_start(20);
        serve_reqs(PKT_WORDS);
        finish_pkt();
        @(negedge clk);
        check("pkt_cnt_after_reset", 32'(bus.pkt_cnt), 32'(1));
        @(posedge clk); #1;
        idle_cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
